// File: rtl/e1b_code_loader.sv
// Loads one Galileo E1B spreading code from a 16-bit host stream into code memory, 12 chips per word.
// Optional trailer checksum (CRC-16-CCITT) is enabled by defining E1B_LOADER_CRC_EN.
module e1b_code_loader #(
  parameter int CODE_WORDS = 341,
  parameter int CNT_W      = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din_valid,
  input  logic [15:0]      din,
  output logic             din_ready,
  output logic             mem_rst,
  output logic             wr,
  output logic [11:0]      tos,
  output logic             busy,
  output logic             done,
  output logic             crc_err,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CHECK, DONE} state_t;

  state_t state;
  logic   xfer;
  logic   last_word;

  // Handshake and status flags are pure decodes of the state register, so they
  // change only on the clock edge and carry no combinational path from inputs.
  assign din_ready = (state == LOAD) || (state == CHECK);
  assign mem_rst   = (state == CLEAR);
  assign busy      = (state == CLEAR) || (state == LOAD) || (state == CHECK);
  assign xfer      = din_valid && din_ready;
  assign last_word = (word_cnt == CNT_W'(CODE_WORDS - 1));

`ifdef E1B_LOADER_CRC_EN
  logic [15:0] crc;

  // CRC-16-CCITT, poly 0x1021, MSB-first over the 12 chip bits of one word.
  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc     <= 16'hFFFF;
      crc_err <= 1'b0;
    end else if (start) begin
      crc_err <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          crc     <= 16'hFFFF;
          crc_err <= 1'b0;
        end
        LOAD:    if (xfer) crc <= crc_word(crc, din[11:0]);
        CHECK:   if (xfer) crc_err <= (din != crc);
        default: ;
      endcase
    end
  end
`else
  assign crc_err = 1'b0;
`endif

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // the leading wr <= 0 default makes wr a one-cycle strobe without else-chains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr       <= 1'b0;
      tos      <= '0;
      done     <= 1'b0;
      word_cnt <= '0;
    end else begin
      wr <= 1'b0;
      if (start) begin
        // Abort-and-restart from any state; a word offered this cycle is dropped.
        state    <= CLEAR;
        done     <= 1'b0;
        word_cnt <= '0;
      end else begin
        case (state)
          IDLE: ;
          CLEAR: begin
            done     <= 1'b0;
            word_cnt <= '0;
            state    <= LOAD;
          end
          LOAD: begin
            if (xfer) begin
              wr       <= 1'b1;
              tos      <= din[11:0];
              word_cnt <= word_cnt + 1'b1;
              if (last_word) begin
`ifdef E1B_LOADER_CRC_EN
                state <= CHECK;
`else
                state <= DONE;
                done  <= 1'b1;
`endif
              end
            end
          end
          CHECK: begin
            if (xfer) begin
              state <= DONE;
`ifdef E1B_LOADER_CRC_EN
              done  <= (din == crc);
`else
              done  <= 1'b1;
`endif
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/e1b_code_loader.md
E1B_CODE_LOADER -- requirements
Module: e1b_code_loader

Interface
REQ-001 SHALL have parameter CODE_WORDS, default 341, meaning 12-bit code words per E1B code (4092 chips / 12).
REQ-002 SHALL have parameter CNT_W, default 9, meaning width of the word counter (2^CNT_W > CODE_WORDS).
REQ-003 SHALL have port clk, input, 1, the single clock; all state is sampled on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin loading a code.
REQ-006 SHALL have port din_valid, input, 1, host word valid.
REQ-007 SHALL have port din, input, 16, host word; bits [11:0] carry chips, MSB is the first chip.
REQ-008 SHALL have port din_ready, output, 1, loader accepts din this cycle.
REQ-009 SHALL have port mem_rst, output, 1, clears the code memory write address.
REQ-010 SHALL have port wr, output, 1, code memory write strobe.
REQ-011 SHALL have port tos, output, 12, code memory write data.
REQ-012 SHALL have port busy, output, 1, load in progress.
REQ-013 SHALL have port done, output, 1, last load completed successfully.
REQ-014 SHALL have port crc_err, output, 1, last load failed its checksum.
REQ-015 SHALL have port word_cnt, output, CNT_W, words written in the current or last load.

Function
REQ-016 SHALL implement states IDLE, CLEAR, LOAD, CHECK, DONE.
REQ-017 SHALL move IDLE or DONE to CLEAR on start; CLEAR lasts exactly 1 cycle with mem_rst=1, word_cnt<=0, done<=0, crc_err<=0, then goes to LOAD.
REQ-018 SHALL drive din_ready=1 only in LOAD and in CHECK; a transfer is din_valid&&din_ready.
REQ-019 SHALL, for each LOAD transfer, assert wr=1 and tos=din[11:0] on the next cycle (1-cycle registered latency), with wr=1 for exactly one cycle per word; wr=0 at all other times.
REQ-020 SHALL increment word_cnt on each LOAD transfer, leave LOAD after the transfer for which word_cnt reaches CODE_WORDS, and never write more than CODE_WORDS words per load.
REQ-021 SHALL tolerate din_valid gaps of any length in LOAD without a timeout.
REQ-022 SHALL treat start in CLEAR, LOAD or CHECK as abort-and-restart: enter CLEAR next cycle, drop any word accepted in the same cycle (no wr for it), and issue no further writes from the aborted load.
REQ-023 SHALL ignore din_valid in IDLE, CLEAR and DONE (din_ready=0, no wr).
REQ-024 SHALL hold busy=1 in CLEAR, LOAD and CHECK, and busy=0 otherwise.
REQ-025 SHALL hold done and crc_err steady in DONE until the next start.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously enter IDLE with wr=0, tos=0, mem_rst=0, din_ready=0, busy=0, done=0, crc_err=0, word_cnt=0, and CRC register=16'hFFFF.
REQ-027 SHALL, if reset is applied mid-load, write nothing further; the partial load is not flagged (done=0).

Configuration
REQ-028 SHALL, with E1B_LOADER_CRC_EN defined, compute CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) over din[11:0] of every LOAD word, reinitialise it in CLEAR, and go LOAD->CHECK; in CHECK the next transfer is a trailer word (not written), giving done=1, crc_err=0 on match with din[15:0], or done=0, crc_err=1 on mismatch; the state then moves to DONE.
REQ-029 SHALL, without E1B_LOADER_CRC_EN, omit the CRC logic, go LOAD->DONE with done=1, tie crc_err to 0, and never enter CHECK.

Verification
REQ-030 SHALL cover a clean load: start, 341 back-to-back words 0x000..0x154 -> one mem_rst pulse, 341 wr pulses with tos equal to the word each 1 cycle later, word_cnt=341, done=1, busy=0.
REQ-031 SHALL cover throttled input: the same 341 words with din_valid toggling 1/0 -> identical wr/tos sequence and no extra or lost writes.
REQ-032 SHALL cover abort: start again after 100 words -> second mem_rst, word_cnt=0, then 341 fresh writes; the aborted word in the restart cycle is never written.
REQ-033 SHALL cover CRC (macro defined): correct trailer -> done=1, crc_err=0, 341 wr pulses; trailer XOR 0x0001 -> crc_err=1, done=0, and the trailer not written.
REQ-034 SHALL cover reset mid-load: rst_n low at word 200 -> all outputs at reset values immediately, no wr after deassertion until a new start.
REQ-035 SHALL cover idle input: din_valid=1 for 50 cycles in IDLE and DONE -> din_ready=0, wr=0 throughout.
